// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths, LFO clamp limit and FSM state type for the tremolo block
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LFO_W    = 32;
    localparam int GAIN_W   = 16;

    localparam logic signed [LFO_W-1:0] LFO_LIM = 32'sh4000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAIN,
        S_MUL,
        S_OUT
    } tremolo_state_t;

endpackage

// File: rtl/tremolo_gain.sv
// rtl/tremolo_gain.sv - combinational map from (lfo, depth) to a Q0.16 gain
module tremolo_gain
    import audio_pkg::*;
(
    input  logic signed [LFO_W-1:0]  lfo_i,
    input  logic        [3:0]        depth_i,
    output logic        [GAIN_W-1:0] gain_o
);

    logic signed [LFO_W-1:0] lfo_c;
    logic        [LFO_W-1:0] offs;
    logic        [16:0]      u;
    logic        [15:0]      u_sat;
    logic        [15:0]      a;
    logic        [19:0]      scaled;

    always_comb begin
        lfo_c = lfo_i;
        if (lfo_i > LFO_LIM) begin
            lfo_c = LFO_LIM;
        end else if (lfo_i < -LFO_LIM) begin
            lfo_c = -LFO_LIM;
        end
        // Offset range is 0..2^31, so the unsigned view never wraps.
        offs   = lfo_c + LFO_LIM;
        u      = 17'(offs >> 15);
        u_sat  = u[16] ? 16'hFFFF : u[15:0];
        a      = 16'hFFFF - u_sat;
        scaled = 20'(a) * 20'(depth_i);
        gain_o = 16'hFFFF - 16'(scaled >> 4);
    end

endmodule

// File: rtl/lfo_tremolo.sv
// rtl/lfo_tremolo.sv - LFO-driven tremolo gain stage with valid/ready on both sides
module lfo_tremolo
    import audio_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic        [3:0]          i_depth,
    input  logic signed [LFO_W-1:0]    i_lfo,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic                       i_sample_valid,
    output logic                       o_sample_ready,
    output logic signed [SAMPLE_W-1:0] o_sample,
    output logic                       o_sample_valid,
    input  logic                       i_sample_ready
);

    tremolo_state_t             state_q;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic signed [LFO_W-1:0]    lfo_q;
    logic        [3:0]          depth_q;
    logic                       bypass_q;
    logic        [GAIN_W-1:0]   gain_q;
    logic signed [SAMPLE_W-1:0] out_q;
    logic                       valid_q;
    logic                       ready_q;

    logic        [GAIN_W-1:0]   gain_d;
    logic signed [33:0]         prod;
    logic signed [33:0]         rnd;
    logic signed [17:0]         y_wide;
    logic signed [SAMPLE_W-1:0] y_d;

    tremolo_gain u_gain (
        .lfo_i   (lfo_q),
        .depth_i (depth_q),
        .gain_o  (gain_d)
    );

    always_comb begin
        prod   = $signed({{18{sample_q[SAMPLE_W-1]}}, sample_q}) * $signed({18'b0, gain_q});
        rnd    = prod + 34'sd32768;
        y_wide = 18'(rnd >>> 16);
        if (bypass_q) begin
            y_d = sample_q;
        end else if (y_wide > 18'sd32767) begin
            y_d = 16'sh7FFF;
        end else if (y_wide < -18'sd32768) begin
            y_d = 16'sh8000;
        end else begin
            y_d = y_wide[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            sample_q <= '0;
            lfo_q    <= '0;
            depth_q  <= '0;
            bypass_q <= 1'b0;
            gain_q   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_sample_valid && ready_q) begin
                        sample_q <= i_sample;
                        lfo_q    <= i_lfo;
                        depth_q  <= i_depth;
                        bypass_q <= !i_start;
                        ready_q  <= 1'b0;
                        state_q  <= S_GAIN;
                    end
                end
                S_GAIN: begin
                    gain_q  <= gain_d;
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    out_q   <= y_d;
                    valid_q <= 1'b1;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    if (i_sample_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sample       = out_q;
    assign o_sample_valid = valid_q;
    assign o_sample_ready = ready_q;

endmodule
